// File: rtl/prof_ctr_bank.sv
// prof_ctr_bank: bank of per-event profiling counters with CSR access, shadowed high-half reads and overflow interrupt
module prof_ctr_bank #(
  parameter int NUM_EVT  = 8,
  parameter int CTR_W    = 48,
  parameter int SAT_MODE = 0,
  parameter int ADDR_W   = 6
) (
  input  logic               Clk,
  input  logic               Rest,
  input  logic [NUM_EVT-1:0] EvtVec,
  input  logic               Freeze,
  input  logic               ClrAll,
  input  logic               CsrRdEn,
  input  logic [ADDR_W-1:0]  CsrRdAddr,
  output logic [31:0]        CsrRdData,
  output logic               CsrRdValid,
  input  logic               CsrWrEn,
  input  logic [ADDR_W-1:0]  CsrWrAddr,
  input  logic [31:0]        CsrWrData,
  output logic               OvfIrq
);
  localparam int HW = CTR_W - 32;
  localparam int CTRL = 2 * NUM_EVT;
  localparam int STAT = CTRL + 1;
  logic [CTR_W-1:0] ctr [NUM_EVT];
  logic [CTR_W-1:0] ctrNxt [NUM_EVT];
  logic [NUM_EVT-1:0] enMask, irqMask, ovfSticky, enNxt, irqNxt, ovfNxt, ovfSet;
  logic [HW-1:0] shadow, shadowNxt;
  logic [31:0] rdData;
  int rdWord, wrWord;
  always_comb begin
    rdWord = int'(CsrRdAddr);
    wrWord = int'(CsrWrAddr);
    rdData = '0;
    shadowNxt = shadow;
    ovfSet = '0;
    enNxt = (CsrWrEn && wrWord == CTRL) ? CsrWrData[NUM_EVT-1:0] : enMask;
    irqNxt = (CsrWrEn && wrWord == CTRL) ? CsrWrData[NUM_EVT+15:16] : irqMask;
    if (rdWord == CTRL) rdData = 32'(enMask) | (32'(irqMask) << 16);
    if (rdWord == STAT) rdData = 32'(ovfSticky);
    for (int i = 0; i < NUM_EVT; i++) begin
      if (rdWord == 2 * i) begin
        rdData = ctr[i][31:0];
        if (CsrRdEn) shadowNxt = ctr[i][CTR_W-1:32];
      end
      if (rdWord == 2 * i + 1) rdData = 32'(shadow);
      ctrNxt[i] = ctr[i];
      // a CSR write to a counter swallows any same-cycle event on it
      if (CsrWrEn && wrWord == 2 * i) ctrNxt[i][31:0] = CsrWrData;
      else if (CsrWrEn && wrWord == 2 * i + 1) ctrNxt[i][CTR_W-1:32] = CsrWrData[HW-1:0];
      else if (EvtVec[i] && enMask[i] && !Freeze) begin
        ovfSet[i] = &ctr[i];
        ctrNxt[i] = &ctr[i] ? (SAT_MODE != 0 ? ctr[i] : '0) : ctr[i] + 1'b1;
      end
      if (ClrAll) ctrNxt[i] = '0;
    end
    ovfNxt = ClrAll ? '0 : (ovfSticky & ~((CsrWrEn && wrWord == STAT) ? CsrWrData[NUM_EVT-1:0] : '0)) | ovfSet;
  end
  always_ff @(posedge Clk) begin
    if (!Rest) begin
      for (int i = 0; i < NUM_EVT; i++) ctr[i] <= '0;
      enMask <= '1;
      irqMask <= '0;
      ovfSticky <= '0;
      shadow <= '0;
      CsrRdData <= '0;
      CsrRdValid <= 1'b0;
      OvfIrq <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_EVT; i++) ctr[i] <= ctrNxt[i];
      enMask <= enNxt;
      irqMask <= irqNxt;
      ovfSticky <= ovfNxt;
      shadow <= shadowNxt;
      CsrRdValid <= CsrRdEn;
      if (CsrRdEn) CsrRdData <= rdData;
      OvfIrq <= |(ovfNxt & irqNxt);
    end
  end
endmodule
